id_stage: RTL and testbench

- Decode/issue stage directly upstream of the integer ALU.
- Accepts one 32-bit RV32I instruction word per handshake and reads the integer register file.
- Stalls on read-after-write hazards using a busy-bit scoreboard.
- Presents registered operands plus opcode, funct3, funct7 and rd to the ALU/execute stage; the writeback port returns results into the register file.

---
 rtl/id_stage_pkg.sv | 46 ++++
 rtl/id_stage_regfile.sv | 44 ++++
 rtl/id_stage.sv | 137 +++++++++++++
 tb/tb_id_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared constants, opcode encodings and source/dest usage decode
package id_stage_pkg;

    localparam int XLEN_WIDTH = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] INST_OP_TYPE_R      = 7'b0110011;
    localparam logic [6:0] INST_OP_TYPE_I      = 7'b0010011;
    localparam logic [6:0] INST_OP_TYPE_LOAD   = 7'b0000011;
    localparam logic [6:0] INST_OP_TYPE_STORE  = 7'b0100011;
    localparam logic [6:0] INST_OP_TYPE_BRANCH = 7'b1100011;
    localparam logic [6:0] INST_OP_TYPE_JAL    = 7'b1101111;
    localparam logic [6:0] INST_OP_TYPE_JALR   = 7'b1100111;
    localparam logic [6:0] INST_OP_TYPE_LUI    = 7'b0110111;
    localparam logic [6:0] INST_OP_TYPE_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } usage_t;

    // Unknown opcodes read nothing and write nothing; rd=x0 never counts as a write.
    function automatic usage_t decode_usage(input logic [6:0] op, input logic [REG_ADDR_W-1:0] rd);
        usage_t u;
        u = '0;
        case (op)
            INST_OP_TYPE_R:      begin u.uses_rs1 = 1'b1; u.uses_rs2 = 1'b1; u.writes_rd = 1'b1; end
            INST_OP_TYPE_I:      begin u.uses_rs1 = 1'b1; u.writes_rd = 1'b1; end
            INST_OP_TYPE_LOAD:   begin u.uses_rs1 = 1'b1; u.writes_rd = 1'b1; end
            INST_OP_TYPE_STORE:  begin u.uses_rs1 = 1'b1; u.uses_rs2 = 1'b1; end
            INST_OP_TYPE_BRANCH: begin u.uses_rs1 = 1'b1; u.uses_rs2 = 1'b1; end
            INST_OP_TYPE_JALR:   begin u.uses_rs1 = 1'b1; u.writes_rd = 1'b1; end
            INST_OP_TYPE_JAL:    u.writes_rd = 1'b1;
            INST_OP_TYPE_LUI:    u.writes_rd = 1'b1;
            INST_OP_TYPE_AUIPC:  u.writes_rd = 1'b1;
            default:             u = '0;
        endcase
        if (rd == '0) begin
            u.writes_rd = 1'b0;
        end
        return u;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// rtl/id_stage_regfile.sv - integer register file, 2 read ports with write-through bypass, x0 hardwired
module id_stage_regfile
    import id_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_WIDTH,
    parameter int REG_COUNT = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    output logic [XLEN-1:0]       rdata1_o,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [XLEN-1:0]       rdata2_o,
    input  logic                  wen_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]       wdata_i
);

    logic [XLEN-1:0] regs_q [REG_COUNT];

    // Storage: whole file clears on reset; writes to x0 are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: x0 reads zero, a same-cycle write to the index is forwarded.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (raddr1_i != '0) begin
            rdata1_o = (wen_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
        end
        if (raddr2_i != '0) begin
            rdata2_o = (wen_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode/issue stage with busy-bit RAW scoreboard feeding the ALU
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_WIDTH,
    parameter int REG_COUNT = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid,
    // Combinational on inst contents (via hazard); fetch must not gate inst_valid on inst_ready.
    output logic                  inst_ready,
    input  logic [31:0]           inst,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       rs1,
    output logic [XLEN-1:0]       rs2,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data
);

    logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]       rf_rdata1, rf_rdata2;
    usage_t                use_s;
    logic                  hazard, issue;

    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic                  ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]       rs1_q, rs1_d, rs2_q, rs2_d;
    logic [6:0]            opcode_q, opcode_d, funct7_q, funct7_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    assign rs1_idx = inst[19:15];
    assign rs2_idx = inst[24:20];
    assign rd_idx  = inst[11:7];
    assign use_s   = decode_usage(inst[6:0], rd_idx);

    id_stage_regfile #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs1_idx),
        .rdata1_o (rf_rdata1),
        .raddr2_i (rs2_idx),
        .rdata2_o (rf_rdata2),
        .wen_i    (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    // Hazard: a busy source stalls unless its writeback lands this very cycle.
    always_comb begin
        hazard = (use_s.uses_rs1 && busy_q[rs1_idx] && !(wb_en && (wb_addr == rs1_idx))) ||
                 (use_s.uses_rs2 && busy_q[rs2_idx] && !(wb_en && (wb_addr == rs2_idx)));
    end

    assign inst_ready = !flush && !hazard && (!ex_valid_q || ex_ready);
    assign issue      = inst_valid && inst_ready;

    // Scoreboard next state: writeback clear first, issue set overrides it, flush wipes all.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue && use_s.writes_rd) begin
            busy_d[rd_idx] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // Output bundle next state: capture on issue, otherwise hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        rd_d       = rd_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
        if (issue) begin
            rs1_d    = rf_rdata1;
            rs2_d    = rf_rdata2;
            opcode_d = inst[6:0];
            funct3_d = inst[14:12];
            funct7_d = inst[31:25];
            rd_d     = rd_idx;
        end
    end

    // State registers for scoreboard and the registered output bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            rd_q       <= '0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            rd_q       <= rd_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign rs1      = rs1_q;
    assign rs2      = rs2_q;
    assign opcode   = opcode_q;
    assign funct3   = funct3_q;
    assign funct7   = funct7_q;
    assign rd_addr  = rd_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage against a behavioural reference model
module tb_id_stage;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0, inst_ready, flush = 1'b0;
    logic [31:0] inst = '0;
    logic        ex_valid, ex_ready = 1'b1;
    logic [31:0] rs1, rs2, wb_data = '0;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr, wb_addr = '0;
    logic        wb_en = 1'b0;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_exv;
    logic [31:0] m_rs1, m_rs2;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [6:0]  ops [10];

    id_stage dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .rs1(rs1), .rs2(rs2),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd_addr(rd_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {f7, s2, s1, f3, d, op};
    endfunction

    function automatic bit m_u1(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LD || op == OP_ST || op == OP_BR || op == OP_JALR;
    endfunction

    function automatic bit m_u2(input logic [6:0] op);
        return op == OP_R || op == OP_ST || op == OP_BR;
    endfunction

    function automatic bit m_wr(input logic [6:0] op, input logic [4:0] d);
        return d != 0 && (op == OP_R || op == OP_I || op == OP_LD || op == OP_LUI ||
                          op == OP_AUIPC || op == OP_JAL || op == OP_JALR);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_reg[idx];
    endfunction

    function automatic bit model_ready();
        logic [4:0] a, b;
        bit stall;
        a = inst[19:15];
        b = inst[24:20];
        stall = (m_u1(inst[6:0]) && m_busy[a] && !(wb_en && wb_addr == a)) ||
                (m_u2(inst[6:0]) && m_busy[b] && !(wb_en && wb_addr == b));
        return !flush && !stall && (!m_exv || ex_ready);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_exv = 0; m_rs1 = '0; m_rs2 = '0; m_op = '0; m_f3 = '0; m_f7 = '0; m_rd = '0;
    endtask

    // One clock edge: advance the model with the inputs currently driven, then settle.
    task automatic step();
        bit iss;
        @(posedge clk);
        iss = inst_valid && model_ready();
        if (iss) begin
            m_rs1 = m_read(inst[19:15]);
            m_rs2 = m_read(inst[24:20]);
            m_op = inst[6:0]; m_f3 = inst[14:12]; m_f7 = inst[31:25]; m_rd = inst[11:7];
        end
        if (flush) m_exv = 0;
        else if (iss) m_exv = 1;
        else if (ex_ready) m_exv = 0;
        if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
        if (wb_en) m_busy[wb_addr] = 0;
        if (iss && m_wr(inst[6:0], inst[11:7])) m_busy[inst[11:7]] = 1;
        if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
        #1;
    endtask

    task automatic idle();
        inst_valid = 0; wb_en = 0; flush = 0; ex_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ex_valid, rs1, rs2, opcode, funct3, funct7, rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%b rs1=%h rs2=%h op=%b rd=%0d, want all 0",
                     ex_valid, rs1, rs2, opcode, rd_addr);
        end
        rst = 0;
        inst = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP_R);
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", inst_ready); end
    endtask

    task automatic test_basic();
        wb_en = 1; wb_addr = 1; wb_data = 5; step();
        wb_addr = 2; wb_data = 7; step();
        wb_en = 0;
        inst = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP_R);
        inst_valid = 1; ex_ready = 1;
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", inst_ready); end
        step();
        inst_valid = 0;
        checks++;
        if (ex_valid !== 1'b1 || rs1 !== 32'd5 || rs2 !== 32'd7 || opcode !== 7'b0110011 || rd_addr !== 5'd3) begin
            errors++;
            $display("FAIL basic_bundle: got ev=%b rs1=%0d rs2=%0d op=%b rd=%0d want 1 5 7 0110011 3",
                     ex_valid, rs1, rs2, opcode, rd_addr);
        end
        inst = enc(7'd0, 5'd0, 5'd3, 3'd0, 5'd7, OP_R);
        inst_valid = 1;
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin errors++; $display("FAIL basic_busy3: got ready=%b want 0", inst_ready); end
    endtask

    task automatic test_raw();
        inst = enc(7'b0100000, 5'd1, 5'd3, 3'd0, 5'd4, OP_R);
        inst_valid = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (inst_ready !== 1'b0) begin errors++; $display("FAIL raw_stall%0d: got %b want 0", i, inst_ready); end
            step();
        end
        wb_en = 1; wb_addr = 3; wb_data = 12;
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b want 1", inst_ready); end
        step();
        wb_en = 0;
        checks++;
        if (ex_valid !== 1'b1 || rs1 !== 32'd12 || rs2 !== 32'd5 || funct7 !== 7'b0100000 || rd_addr !== 5'd4) begin
            errors++;
            $display("FAIL raw_bypass: got ev=%b rs1=%0d rs2=%0d f7=%b rd=%0d want 1 12 5 0100000 4",
                     ex_valid, rs1, rs2, funct7, rd_addr);
        end
    endtask

    task automatic test_backpressure();
        ex_ready = 0;
        inst = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd5, OP_R);
        inst_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (inst_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b want 0", i, inst_ready); end
            step();
            checks++;
            if (ex_valid !== 1'b1 || rs1 !== 32'd12 || rs2 !== 32'd5 || rd_addr !== 5'd4) begin
                errors++;
                $display("FAIL bp_hold%0d: got ev=%b rs1=%0d rs2=%0d rd=%0d want 1 12 5 4",
                         i, ex_valid, rs1, rs2, rd_addr);
            end
        end
        ex_ready = 1;
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", inst_ready); end
        step();
        inst_valid = 0;
        checks++;
        if (ex_valid !== 1'b1 || rs1 !== 32'd5 || rs2 !== 32'd7 || rd_addr !== 5'd5) begin
            errors++;
            $display("FAIL bp_next: got ev=%b rs1=%0d rs2=%0d rd=%0d want 1 5 7 5", ex_valid, rs1, rs2, rd_addr);
        end
        step();
    endtask

    task automatic test_x0();
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
        inst = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd10, OP_R);
        inst_valid = 1;
        step();
        wb_en = 0;
        checks++;
        if (ex_valid !== 1'b1 || rs1 !== 32'd0 || rs2 !== 32'd0) begin
            errors++;
            $display("FAIL x0_read: got ev=%b rs1=%h rs2=%h want 1 0 0", ex_valid, rs1, rs2);
        end
        inst = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, OP_R);
        step();
        inst = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd11, OP_R);
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin errors++; $display("FAIL x0_nostall: got %b want 1", inst_ready); end
        step();
        inst_valid = 0;
        step();
    endtask

    task automatic test_flush();
        inst = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP_R);
        inst_valid = 1;
        step();
        flush = 1;
        inst = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd12, OP_R);
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", inst_ready); end
        step();
        flush = 0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
        inst = enc(7'd0, 5'd3, 5'd3, 3'd0, 5'd6, OP_R);
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin errors++; $display("FAIL flush_busyclr: got %b want 1", inst_ready); end
        step();
        inst_valid = 0;
        checks++;
        if (ex_valid !== 1'b1 || rs1 !== 32'd12 || rs2 !== 32'd12 || rd_addr !== 5'd6) begin
            errors++;
            $display("FAIL flush_issue: got ev=%b rs1=%0d rs2=%0d rd=%0d want 1 12 12 6", ex_valid, rs1, rs2, rd_addr);
        end
        step();
    endtask

    task automatic test_random();
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b0001111};
        for (int n = 0; n < 300; n++) begin
            inst = enc(7'($urandom()), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       3'($urandom()), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]);
            inst_valid = ($urandom_range(0, 3) != 0);
            ex_ready   = ($urandom_range(0, 3) != 0);
            wb_en      = ($urandom_range(0, 2) == 0);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom();
            flush      = ($urandom_range(0, 19) == 0);
            #1;
            checks++;
            if (inst_ready !== model_ready()) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b inst=%h", n, inst_ready, model_ready(), inst);
            end
            step();
            checks++;
            if ({ex_valid, rs1, rs2, opcode, funct3, funct7, rd_addr} !== {m_exv, m_rs1, m_rs2, m_op, m_f3, m_f7, m_rd}) begin
                errors++;
                $display("FAIL rand_bundle[%0d]: got %b %h %h %b %0d want %b %h %h %b %0d", n,
                         ex_valid, rs1, rs2, opcode, rd_addr, m_exv, m_rs1, m_rs2, m_op, m_rd);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        flush = 1; step(); flush = 0;
        inst = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP_R);
        inst_valid = 1;
        step();
        ex_ready = 0;
        inst = enc(7'b0100000, 5'd1, 5'd3, 3'd0, 5'd4, OP_R);
        #1;
        checks++;
        if (inst_ready !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b want 0", inst_ready); end
        #2;
        rst = 1;
        #1;
        checks++;
        if ({ex_valid, rs1, rs2, opcode, funct3, funct7, rd_addr} !== '0) begin
            errors++;
            $display("FAIL ar_immediate: got ev=%b rs1=%h rs2=%h op=%b rd=%0d want all 0",
                     ex_valid, rs1, rs2, opcode, rd_addr);
        end
        model_reset();
        inst_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        ex_ready = 1;
        inst = enc(7'd0, 5'd0, 5'd1, 3'd0, 5'd9, OP_R);
        inst_valid = 1;
        #1;
        checks++;
        if (inst_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", inst_ready); end
        step();
        inst_valid = 0;
        checks++;
        if (ex_valid !== 1'b1 || rs1 !== 32'd0 || rd_addr !== 5'd9) begin
            errors++;
            $display("FAIL ar_regclr: got ev=%b rs1=%h rd=%0d want 1 0 9", ex_valid, rs1, rd_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_backpressure();
        test_x0();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
